controller: RTL
===============

# controller

Multi-cycle control unit for the ARM32 core; it sits directly upstream of `datapath` and drives all of that block's control inputs. It fetches one 32-bit instruction per pass from instruction memory, decodes the ARM data-processing class, evaluates the condition field against the datapath status flags, and sequences register read, execute and write-back. It also owns the program counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ins_data` in 32: instruction memory read data, valid one cycle after `ins_rd_en`.
- `status_in` in 32: datapath `status_out`, with N,Z,C,V in bits 31:28.
- `ins_rd_en` out 1: instruction memory read strobe; the address is `PC`.
- `PC` out 32: program counter. It also feeds datapath `PC`.
- `A_addr`, `B_addr`, `shift_addr`, `w_addr1` out 4: register file addresses.
- `en_A`, `en_B`, `en_S`, `w_en1`, `en_status1` out 1: load and write enables.
- `sel_A`, `sel_B`, `sel_shift`, `sel_post_shift` out 1: datapath mux selects. `sel_post_shift` is always 0.
- `shift_op` out 2: shift type (LSL, LSR, ASR, ROR).
- `ALU_op` out 3: ALU operation.
- `shift_imme`, `imme_data` out 32: shift amount and expanded immediate.

## Operation
- States are FETCH, FETCH_WAIT, DECODE, EXECUTE, WRITE_BACK. Transitions are unconditional in that order, then back to FETCH.
- FETCH: `ins_rd_en`=1.
- FETCH_WAIT: `ins_rd_en`=0. IR loads `ins_data` on the exiting edge.
- DECODE:
  - `A_addr`=IR[19:16], `B_addr`=IR[3:0], `shift_addr`=IR[11:8]; `en_A`=`en_B`=`en_S`=1.
  - Register shift (IR[25]=0, IR[4]=1): `sel_shift`=1.
  - Otherwise: `sel_shift`=0 and `shift_imme`={27'b0, IR[11:7]}.
  - `cond_pass` is registered on the exiting edge from IR[31:28] and `status_in[31:28]`, using the full ARM table for codes 0000–1110. Code 1111 never passes.
- EXECUTE:
  - `shift_op`=IR[6:5].
  - `sel_B`=IR[25]. When IR[25]=1, `imme_data`=IR[7:0] rotated right by 2·IR[11:8].
  - `sel_A`=1 only for MOV, which selects zero on the A side.
  - `ALU_op` from the opcode: AND→010, EOR→100, SUB→001, ADD→000, CMP→001, ORR→011, MOV→000.
  - `en_status1`=1 if IR[20]=1 and `cond_pass` and the opcode is supported.
- WRITE_BACK:
  - `w_en1`=1, `w_addr1`=IR[15:12] if `cond_pass`, the opcode is supported, and the opcode is not CMP.
  - Execute-phase selects are held so the write data is stable.
  - PC←PC+4 on the exiting edge.
- Unsupported instructions (IR[27:26]≠00, or opcode not in the list) execute as NOPs: no `w_en1`, no `en_status1`, PC still advances.
- All outputs not listed for a state are 0 in that state.

## Timing
- Moore outputs, decoded from the state register and IR only. There is no combinational path from `ins_data` or `status_in` to any output.
- 5 cycles per instruction. The register write and the PC update occur on the same edge, which ends WRITE_BACK.
- Status is written on the EXECUTE edge, so the next instruction's DECODE sees it. Back-to-back conditional execution is therefore exact.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- Reset values: state FETCH, PC=`RESET_PC`, IR=0, `cond_pass`=0.
- During reset `ins_rd_en` is 0. The first FETCH cycle, with `ins_rd_en`=1, follows reset deassertion.
- Reset asserted mid-instruction aborts it immediately. No pending write or status update occurs.

## Structure
- Package `arm_pkg` holds:
  - the state enum;
  - ALU_op constants (ADD 000, SUB 001, AND 010, ORR 011, EOR 100);
  - shift type constants;
  - data-processing opcode constants;
  - cond code constants.
- Sub-module `cond_check` is the combinational cond/NZCV evaluator, reused later by branch logic.
- The immediate rotator stays inline.

## Test plan
- Reset:
  - Stimulus: assert `rst`, release.
  - Response: all outputs 0 and PC=0 during reset; `ins_rd_en`=1 in the first cycle after release.
- MOV immediate:
  - Stimulus: `ins_data`=32'hE3A0_1005, MOV r1,#5.
  - Response: in EXECUTE, `imme_data`=5, `sel_A`=`sel_B`=1, `ALU_op`=000. In WRITE_BACK, `w_en1`=1, `w_addr1`=1. PC=4 five cycles after FETCH.
- Rotated immediate:
  - Stimulus: 32'hE3A0_14FF.
  - Response: `imme_data`=32'hFF00_0000.
- Shifted register ADD:
  - Stimulus: 32'hE081_3102, ADD r3,r1,r2,LSL#2.
  - Response: in DECODE, `A_addr`=1, `B_addr`=2, `shift_imme`=2, `sel_shift`=0. `w_addr1`=3 in WRITE_BACK.
- Condition handling:
  - Stimulus: CMP r1,r2 (32'hE151_0002).
  - Response: `en_status1`=1 with `ALU_op`=001, `w_en1` stays 0.
  - Stimulus: ADDEQ 32'h0081_3102 with `status_in`=0.
  - Response: no `w_en1` and no `en_status1`; PC still +4.
- Mid-instruction reset:
  - Stimulus: `rst` pulsed during EXECUTE.
  - Response: outputs drop to 0 asynchronously, PC=0, no write-back follows, fetch restarts at 0.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM32 control encodings: FSM states, ALU/shift/opcode/cond constants
package arm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXECUTE    = 3'd3,
    ST_WRITE_BACK = 3'd4
  } state_t;

  // ALU operation codes as understood by datapath
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // Barrel shifter types, same encoding as IR[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Data-processing opcodes, IR[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  // Condition codes, IR[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // True for the data-processing opcodes this core implements
  function automatic logic op_supported(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_SUB) || (op == OP_ADD) ||
           (op == OP_CMP) || (op == OP_ORR) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-code evaluator against NZCV
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Full ARM condition table; the NV encoding never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - five-state multi-cycle ARM32 data-processing control unit and PC owner
module controller
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_data,
  input  logic [31:0] status_in,
  output logic        ins_rd_en,
  output logic [31:0] PC,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic [3:0]  w_addr1,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        w_en1,
  output logic        en_status1,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_shift,
  output logic        sel_post_shift,
  output logic [1:0]  shift_op,
  output logic [2:0]  ALU_op,
  output logic [31:0] shift_imme,
  output logic [31:0] imme_data
);

  state_t      state;
  logic [31:0] ir;
  logic        cond_pass;
  logic        cond_now;

  logic [3:0]  opcode;
  logic        supported;
  logic        reg_shift;
  logic [2:0]  alu_dec;
  logic [63:0] rot_wide;
  logic        status_unused;

  assign status_unused = ^status_in[27:0];

  cond_check u_cond_check (
    .cond (ir[31:28]),
    .nzcv (status_in[31:28]),
    .pass (cond_now)
  );

  assign opcode    = ir[24:21];
  assign supported = (ir[27:26] == 2'b00) && op_supported(opcode);
  assign reg_shift = !ir[25] && ir[4];

  // Immediate rotate-right by twice the rotate field, done on a doubled word
  assign rot_wide = {24'b0, ir[7:0], 24'b0, ir[7:0]} >> {ir[11:8], 1'b0};

  // Opcode to ALU operation; MOV and unsupported opcodes fall to ADD
  always_comb begin
    alu_dec = ALU_ADD;
    case (opcode)
      OP_AND:         alu_dec = ALU_AND;
      OP_EOR:         alu_dec = ALU_EOR;
      OP_SUB, OP_CMP: alu_dec = ALU_SUB;
      OP_ORR:         alu_dec = ALU_ORR;
      default:        alu_dec = ALU_ADD;
    endcase
  end

  // State sequencing, IR capture, condition latch and PC advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      PC        <= RESET_PC;
      ir        <= 32'h0;
      cond_pass <= 1'b0;
    end else begin
      case (state)
        ST_FETCH:      state <= ST_FETCH_WAIT;
        ST_FETCH_WAIT: begin
          ir    <= ins_data;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          cond_pass <= cond_now;
          state     <= ST_EXECUTE;
        end
        ST_EXECUTE:    state <= ST_WRITE_BACK;
        ST_WRITE_BACK: begin
          PC    <= PC + 32'd4;
          state <= ST_FETCH;
        end
        default:       state <= ST_FETCH;
      endcase
    end
  end

  // Moore outputs from state and IR; anything not driven by a state stays 0
  always_comb begin
    ins_rd_en      = 1'b0;
    A_addr         = 4'h0;
    B_addr         = 4'h0;
    shift_addr     = 4'h0;
    w_addr1        = 4'h0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    w_en1          = 1'b0;
    en_status1     = 1'b0;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_shift      = 1'b0;
    sel_post_shift = 1'b0;
    shift_op       = 2'b00;
    ALU_op         = 3'b000;
    shift_imme     = 32'h0;
    imme_data      = 32'h0;
    case (state)
      ST_FETCH: ins_rd_en = !rst;
      ST_DECODE: begin
        A_addr     = ir[19:16];
        B_addr     = ir[3:0];
        shift_addr = ir[11:8];
        en_A       = 1'b1;
        en_B       = 1'b1;
        en_S       = 1'b1;
        sel_shift  = reg_shift;
        if (!reg_shift) shift_imme = {27'b0, ir[11:7]};
      end
      ST_EXECUTE, ST_WRITE_BACK: begin
        shift_op  = ir[6:5];
        sel_B     = ir[25];
        if (ir[25]) imme_data = rot_wide[31:0];
        sel_A     = supported && (opcode == OP_MOV);
        ALU_op    = alu_dec;
        if (state == ST_EXECUTE) begin
          en_status1 = ir[20] && cond_pass && supported;
        end else if (cond_pass && supported && (opcode != OP_CMP)) begin
          w_en1   = 1'b1;
          w_addr1 = ir[15:12];
        end
      end
      default: ;
    endcase
  end

endmodule
